// File: rtl/ext_in_debounce.sv
// Synchroniser and debouncer for one raw external input, with edge pulses and counters.
// Define EXT_IN_DEBOUNCE_GLITCH_CNT_EN to add the saturating glitch_cnt_o rejection counter.
module ext_in_debounce #(
    parameter int       SYNC_STAGES     = 2,
    parameter int       DEBOUNCE_CYCLES = 50000,
    parameter int       CNT_W           = 16,
    parameter bit       RESET_LEVEL     = 1'b0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ext_in,
    input  logic        clear_i,
    output logic        level_o,
    output logic        rise_o,
    output logic        fall_o,
    output logic [15:0] edge_cnt_o
`ifdef EXT_IN_DEBOUNCE_GLITCH_CNT_EN
    ,
    output logic [7:0]  glitch_cnt_o
`endif
);

    typedef enum logic {
        STABLE  = 1'b0,
        QUALIFY = 1'b1
    } state_t;

    // cnt holds samples already seen; the current sample completes the run
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   sync_q;
    state_t                 state_q;
    state_t                 state_d;
    logic [CNT_W-1:0]       cnt_q;
    logic [CNT_W-1:0]       cnt_d;
    logic                   accept;
    logic                   reject;
    logic                   differ;
    logic                   level_d;
    logic                   rise_d;
    logic                   fall_d;
    logic [15:0]            edge_cnt_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_r <= {SYNC_STAGES{RESET_LEVEL}};
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], ext_in};
        end
    end

    assign sync_q = sync_r[SYNC_STAGES-1];
    assign differ = sync_q != level_o;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= STABLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        accept  = 1'b0;
        reject  = 1'b0;
        unique case (state_q)
            STABLE: begin
                if (differ) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        accept = 1'b1;
                    end else begin
                        state_d = QUALIFY;
                        cnt_d   = CNT_W'(1);
                    end
                end
            end
            QUALIFY: begin
                if (!differ) begin
                    reject  = 1'b1;
                    state_d = STABLE;
                end else if (cnt_q == LAST) begin
                    accept  = 1'b1;
                    state_d = STABLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = STABLE;
            end
        endcase
    end

    always_comb begin
        level_d    = accept ? sync_q : level_o;
        rise_d     = accept & sync_q;
        fall_d     = accept & ~sync_q;
        edge_cnt_d = clear_i ? 16'd0 : edge_cnt_o;
        if (accept) begin
            edge_cnt_d = edge_cnt_d + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            level_o    <= RESET_LEVEL;
            rise_o     <= 1'b0;
            fall_o     <= 1'b0;
            edge_cnt_o <= 16'd0;
        end else begin
            level_o    <= level_d;
            rise_o     <= rise_d;
            fall_o     <= fall_d;
            edge_cnt_o <= edge_cnt_d;
        end
    end

`ifdef EXT_IN_DEBOUNCE_GLITCH_CNT_EN
    logic [7:0] glitch_cnt_d;

    always_comb begin
        glitch_cnt_d = clear_i ? 8'd0 : glitch_cnt_o;
        if (reject && glitch_cnt_d != 8'hFF) begin
            glitch_cnt_d = glitch_cnt_d + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            glitch_cnt_o <= 8'd0;
        end else begin
            glitch_cnt_o <= glitch_cnt_d;
        end
    end
`endif

endmodule

// File: tb/tb_ext_in_debounce.sv
// Bench for ext_in_debounce: scoreboard of expected edge pulses plus per-scenario checks.
// A second instance with a one-sample debounce exercises counter wrap and clear.
module tb_ext_in_debounce;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        ext_in = 1'b0;
    logic        clear_i = 1'b0;
    logic        level_o;
    logic        rise_o;
    logic        fall_o;
    logic [15:0] edge_cnt_o;
    logic        ext1 = 1'b0;
    logic        clear1 = 1'b0;
    logic        level1;
    logic        rise1;
    logic        fall1;
    logic [15:0] edge_cnt1;
`ifdef EXT_IN_DEBOUNCE_GLITCH_CNT_EN
    logic [7:0]  glitch_cnt;
    logic [7:0]  glitch_cnt1;
`endif

    int tests = 0;
    int failed = 0;
    int cyc = 0;

    typedef struct {
        bit          rise;
        bit          level;
        logic [15:0] cnt;
        int          cyc;
    } exp_t;

    exp_t q[$];

    ext_in_debounce #(
        .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .CNT_W(16), .RESET_LEVEL(1'b0)
    ) dut (
        .clk(clk), .reset_n(reset_n), .ext_in(ext_in), .clear_i(clear_i),
        .level_o(level_o), .rise_o(rise_o), .fall_o(fall_o),
`ifdef EXT_IN_DEBOUNCE_GLITCH_CNT_EN
        .glitch_cnt_o(glitch_cnt),
`endif
        .edge_cnt_o(edge_cnt_o)
    );

    ext_in_debounce #(
        .SYNC_STAGES(2), .DEBOUNCE_CYCLES(1), .CNT_W(16), .RESET_LEVEL(1'b0)
    ) dut1 (
        .clk(clk), .reset_n(reset_n), .ext_in(ext1), .clear_i(clear1),
        .level_o(level1), .rise_o(rise1), .fall_o(fall1),
`ifdef EXT_IN_DEBOUNCE_GLITCH_CNT_EN
        .glitch_cnt_o(glitch_cnt1),
`endif
        .edge_cnt_o(edge_cnt1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Edge scoreboard: every pulse must match the head entry at its exact edge
    always @(negedge clk) begin
        exp_t e;
        if (q.size() != 0 && q[0].cyc < cyc) begin
            tests++;
            failed++;
            $display("FAIL missed_edge: no pulse at edge %0d, now %0d", q[0].cyc, cyc);
            void'(q.pop_front());
        end
        if (rise_o || fall_o) begin
            tests++;
            if (q.size() == 0) begin
                failed++;
                $display("FAIL spurious_pulse: rise=%b fall=%b at %0d, none expected",
                         rise_o, fall_o, cyc);
            end else begin
                e = q.pop_front();
                if ({rise_o, fall_o, level_o, edge_cnt_o} !==
                    {e.rise, !e.rise, e.level, e.cnt} || cyc !== e.cyc) begin
                    failed++;
                    $display("FAIL edge_pulse: got r=%b f=%b l=%b cnt=%h @%0d, want r=%b f=%b l=%b cnt=%h @%0d",
                             rise_o, fall_o, level_o, edge_cnt_o, cyc,
                             e.rise, !e.rise, e.level, e.cnt, e.cyc);
                end
            end
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_drained(input string name);
        tests++;
        if (q.size() != 0) begin
            failed++;
            $display("FAIL %s: %0d expected pulses outstanding, want 0", name, q.size());
            q.delete();
        end
    endtask

    task automatic test_reset;
        ext_in  = 1'b0;
        ext1    = 1'b0;
        reset_n = 1'b0;
        wait_cyc(3);
        tests++;
        if ({level_o, rise_o, fall_o, edge_cnt_o} !== 19'd0) begin
            failed++;
            $display("FAIL reset_state: l=%b r=%b f=%b cnt=%h, want all 0",
                     level_o, rise_o, fall_o, edge_cnt_o);
        end
        reset_n = 1'b1;
        wait_cyc(20);
        tests++;
        if (level_o !== 1'b0 || edge_cnt_o !== 16'd0) begin
            failed++;
            $display("FAIL reset_quiet: l=%b cnt=%h, want 0 0", level_o, edge_cnt_o);
        end
        check_drained("reset_pulses");
    endtask

    task automatic test_rise_fall;
        int t0;
        t0 = cyc;
        ext_in = 1'b1;
        q.push_back('{rise: 1'b1, level: 1'b1, cnt: 16'd1, cyc: t0 + 6});
        wait_cyc(5);
        tests++;
        if (level_o !== 1'b0) begin
            failed++;
            $display("FAIL rise_early: level=%b at edge 5, want 0", level_o);
        end
        wait_cyc(5);
        check_drained("rise_pulse");
        tests++;
        if (level_o !== 1'b1 || edge_cnt_o !== 16'd1) begin
            failed++;
            $display("FAIL rise_level: l=%b cnt=%h, want 1 0001", level_o, edge_cnt_o);
        end
        t0 = cyc;
        ext_in = 1'b0;
        q.push_back('{rise: 1'b0, level: 1'b0, cnt: 16'd2, cyc: t0 + 6});
        wait_cyc(10);
        check_drained("fall_pulse");
        tests++;
        if (level_o !== 1'b0 || edge_cnt_o !== 16'd2) begin
            failed++;
            $display("FAIL fall_level: l=%b cnt=%h, want 0 0002", level_o, edge_cnt_o);
        end
    endtask

    task automatic test_glitch;
        ext_in = 1'b1;
        wait_cyc(3);
        ext_in = 1'b0;
        wait_cyc(10);
        tests++;
        if (level_o !== 1'b0 || edge_cnt_o !== 16'd2) begin
            failed++;
            $display("FAIL glitch_reject: l=%b cnt=%h, want 0 0002", level_o, edge_cnt_o);
        end
`ifdef EXT_IN_DEBOUNCE_GLITCH_CNT_EN
        tests++;
        if (glitch_cnt !== 8'd1) begin
            failed++;
            $display("FAIL glitch_count: got %h, want 01", glitch_cnt);
        end
`endif
        check_drained("glitch_pulses");
    endtask

    task automatic test_clear;
        clear_i = 1'b1;
        wait_cyc(1);
        clear_i = 1'b0;
        tests++;
        if (edge_cnt_o !== 16'd0) begin
            failed++;
            $display("FAIL clear_edge_cnt: got %h, want 0000", edge_cnt_o);
        end
`ifdef EXT_IN_DEBOUNCE_GLITCH_CNT_EN
        tests++;
        if (glitch_cnt !== 8'd0) begin
            failed++;
            $display("FAIL clear_glitch_cnt: got %h, want 00", glitch_cnt);
        end
`endif
    endtask

    task automatic test_reset_mid_qualify;
        int t0;
        t0 = cyc;
        ext_in = 1'b1;
        wait_cyc(4);
        reset_n = 1'b0;
        wait_cyc(3);
        tests++;
        if ({level_o, rise_o, fall_o, edge_cnt_o} !== 19'd0) begin
            failed++;
            $display("FAIL midq_in_reset: l=%b r=%b f=%b cnt=%h, want all 0",
                     level_o, rise_o, fall_o, edge_cnt_o);
        end
        wait_cyc(3);
        reset_n = 1'b1;
        q.push_back('{rise: 1'b1, level: 1'b1, cnt: 16'd1, cyc: t0 + 16});
        wait_cyc(5);
        tests++;
        if (level_o !== 1'b0) begin
            failed++;
            $display("FAIL midq_restart: level=%b 5 edges after release, want 0", level_o);
        end
        wait_cyc(5);
        check_drained("midq_pulse");
        tests++;
        if (level_o !== 1'b1) begin
            failed++;
            $display("FAIL midq_level: got %b, want 1", level_o);
        end
        t0 = cyc;
        ext_in = 1'b0;
        q.push_back('{rise: 1'b0, level: 1'b0, cnt: 16'd2, cyc: t0 + 6});
        wait_cyc(10);
        check_drained("midq_fall");
    endtask

`ifdef EXT_IN_DEBOUNCE_GLITCH_CNT_EN
    task automatic test_glitch_sat;
        for (int i = 0; i < 300; i++) begin
            ext_in = 1'b1;
            wait_cyc(2);
            ext_in = 1'b0;
            wait_cyc(4);
        end
        tests++;
        if (glitch_cnt !== 8'hFF || level_o !== 1'b0) begin
            failed++;
            $display("FAIL glitch_sat: cnt=%h l=%b, want FF 0", glitch_cnt, level_o);
        end
        check_drained("glitch_sat_pulses");
        clear_i = 1'b1;
        wait_cyc(1);
        clear_i = 1'b0;
        tests++;
        if (glitch_cnt !== 8'h00) begin
            failed++;
            $display("FAIL glitch_sat_clear: got %h, want 00", glitch_cnt);
        end
    endtask
`endif

    task automatic test_wrap;
        for (int i = 0; i < 65535; i++) begin
            ext1 = ~ext1;
            wait_cyc(1);
        end
        wait_cyc(4);
        tests++;
        if (edge_cnt1 !== 16'hFFFF || level1 !== 1'b1) begin
            failed++;
            $display("FAIL wrap_preload: cnt=%h l=%b, want FFFF 1", edge_cnt1, level1);
        end
        ext1 = 1'b0;
        wait_cyc(3);
        tests++;
        if (edge_cnt1 !== 16'h0000 || level1 !== 1'b0 || fall1 !== 1'b1) begin
            failed++;
            $display("FAIL wrap_zero: cnt=%h l=%b f=%b, want 0000 0 1",
                     edge_cnt1, level1, fall1);
        end
        wait_cyc(3);
        ext1 = 1'b1;
        wait_cyc(2);
        clear1 = 1'b1;
        wait_cyc(1);
        clear1 = 1'b0;
        tests++;
        if (edge_cnt1 !== 16'd1 || level1 !== 1'b1 || rise1 !== 1'b1) begin
            failed++;
            $display("FAIL clear_with_edge: cnt=%h l=%b r=%b, want 0001 1 1",
                     edge_cnt1, level1, rise1);
        end
    endtask

    initial begin
        test_reset();
        test_rise_fall();
        test_glitch();
        test_clear();
        test_reset_mid_qualify();
`ifdef EXT_IN_DEBOUNCE_GLITCH_CNT_EN
        test_glitch_sat();
`endif
        test_wrap();
        wait_cyc(2);
        check_drained("final");
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
